// File: rtl/config_fir_pkg.sv
// Shared definitions for the FIR tap sequencer slice.
// Holds the sequencer state type, the default FIR geometry (tap index width A
// and tap count T) and the bit positions inside the sticky error vector.
// No ports: this is a package imported by the sequencer and its testbench.
package config_fir_pkg;

  typedef enum logic [1:0] {
    S_UNPROG = 2'd0,
    S_FLUSH  = 2'd1,
    S_STREAM = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // Default FIR geometry; must match the configurable_fir instance.
  localparam int NUM_STAGES_LOG2_DEF  = 2;
  localparam int STAGE_DEPTH_LOG2_DEF = 2;
  localparam int A = NUM_STAGES_LOG2_DEF + STAGE_DEPTH_LOG2_DEF;
  localparam int T = 1 << A;

  // Sticky error flag positions in cfg_err.
  localparam int ERR_WR_DROP   = 0;
  localparam int ERR_APPLY_IGN = 1;
  localparam int ERR_TIMEOUT   = 2;
  localparam int ERR_W         = 3;

  // Tap count for an arbitrary stage geometry.
  function automatic int tap_count(input int stages_log2, input int depth_log2);
    return 1 << (stages_log2 + depth_log2);
  endfunction

endpackage

// File: rtl/config_fir_bram.sv
// Shadow tap memory: one synchronous write port and one synchronous read
// port sharing a single clock, one cycle of read latency, read-old-data on a
// same-address collision. Contents are deliberately not reset.
// Ports:
//   clk      - clock
//   wr_en    - write strobe; wr_addr/wr_data captured on the rising edge
//   rd_en    - read strobe; rd_data holds mem[rd_addr] from the next cycle
//   rd_data  - registered read data, holds its value while rd_en is low
module config_fir_bram #(
  parameter int G_ADDR_WIDTH = 4,
  parameter int G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr,
  input  logic [G_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [G_ADDR_WIDTH-1:0] rd_addr,
  output logic [G_DATA_WIDTH-1:0] rd_data
);

  logic [G_DATA_WIDTH-1:0] mem_q [2**G_ADDR_WIDTH];
  logic [G_DATA_WIDTH-1:0] rd_data_q;

  // Plain RAM template without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/config_fir_tap_sequencer.sv
// Programming controller in front of configurable_fir.
// Keeps a shadow copy of every FIR tap, and on cfg_apply flushes the FIR by
// holding fir_enable low, streams taps 0..T-1 over the tap handshake, then
// opens the upstream sample gate.
// Ports:
//   clk, reset_n           - clock, asynchronous active-low reset
//   cfg_wr_addr/data/valid - shadow tap write port (UNPROG and RUN only)
//   cfg_apply              - one-cycle request to reprogram the FIR
//   cfg_err_clear          - clears the sticky error flags
//   cfg_busy               - flushing or streaming
//   cfg_done               - one-cycle pulse after the last tap handshake
//   cfg_programmed         - FIR holds a complete tap set and is running
//   cfg_err                - sticky {timeout, apply ignored, write dropped}
//   fir_enable             - FIR enable, low while unprogrammed or flushing
//   fir_tap_din/_valid     - registered tap stream towards the FIR
//   fir_tap_din_ready      - tap stream ready from the FIR
//   fir_data_gate          - qualifies upstream din_valid, high only in RUN
module config_fir_tap_sequencer
  import config_fir_pkg::*;
#(
  parameter int G_NUM_STAGES_LOG2  = NUM_STAGES_LOG2_DEF,
  parameter int G_STAGE_DEPTH_LOG2 = STAGE_DEPTH_LOG2_DEF,
  parameter int G_TAP_WIDTH        = 16,
  parameter int G_FLUSH_CYCLES     = 2,
  parameter int G_TIMEOUT          = 1024
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]                          cfg_wr_data,
  input  logic                                            cfg_wr_valid,
  input  logic                                            cfg_apply,
  input  logic                                            cfg_err_clear,
  output logic                                            cfg_busy,
  output logic                                            cfg_done,
  output logic                                            cfg_programmed,
  output logic [ERR_W-1:0]                                cfg_err,
  output logic                                            fir_enable,
  output logic [G_TAP_WIDTH-1:0]                          fir_tap_din,
  output logic                                            fir_tap_din_valid,
  input  logic                                            fir_tap_din_ready,
  output logic                                            fir_data_gate
);

  localparam int AW   = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
  localparam int TN   = tap_count(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
  localparam int TO_W = $clog2(G_TIMEOUT + 1);

  localparam logic [AW:0]      RD_END     = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0]    TAP_LAST   = '1;
  localparam logic [3:0]       FLUSH_INIT = 4'(G_FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(G_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [3:0]             flush_q, flush_d;
  logic [AW:0]            rd_idx_q, rd_idx_d;
  logic                   rd_pend_q, rd_pend_d;
  logic [AW-1:0]          tx_idx_q, tx_idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [G_TAP_WIDTH-1:0] out_data_q, out_data_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [G_TAP_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic                   done_q, done_d;
  logic [ERR_W-1:0]       err_q, err_d;

  logic                   wr_en;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [G_TAP_WIDTH-1:0] rd_data;
  logic [ERR_W-1:0]       err_set;
  logic                   handshake;
  logic                   stalled;
  logic                   out_free;
  logic [1:0]             occ;

  config_fir_bram #(
    .G_ADDR_WIDTH (AW),
    .G_DATA_WIDTH (G_TAP_WIDTH)
  ) u_shadow (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign handshake = out_valid_q & fir_tap_din_ready;
  assign stalled   = out_valid_q & ~fir_tap_din_ready;
  assign out_free  = ~out_valid_q | handshake;

  // Taps held or in flight once this cycle's handshake leaves. A new read is
  // only issued when this is below two, so the returning word always finds
  // either the output register or the skid register free.
  assign occ = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(handshake);

  // Next-state logic: control FSM, tap prefetch pipeline and error flags.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    rd_idx_d     = rd_idx_q;
    rd_pend_d    = rd_pend_q;
    tx_idx_d     = tx_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    to_d         = to_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = rd_idx_q[AW-1:0];
    err_set      = '0;

    unique case (state_q)
      S_UNPROG, S_RUN: begin
        // A write issued together with apply lands well before the first
        // shadow read, so the stream always sees it.
        wr_en = cfg_wr_valid;
        if (cfg_apply) begin
          state_d = S_FLUSH;
          flush_d = FLUSH_INIT;
        end
      end

      S_FLUSH: begin
        err_set[ERR_WR_DROP]   = cfg_wr_valid;
        err_set[ERR_APPLY_IGN] = cfg_apply;
        if (flush_q == 4'd0) begin
          state_d      = S_STREAM;
          rd_en        = 1'b1;
          rd_addr      = '0;
          rd_idx_d     = (AW+1)'(1);
          rd_pend_d    = 1'b1;
          tx_idx_d     = '0;
          out_valid_d  = 1'b0;
          skid_valid_d = 1'b0;
          to_d         = '0;
        end else begin
          flush_d = flush_q - 4'd1;
        end
      end

      S_STREAM: begin
        err_set[ERR_WR_DROP]   = cfg_wr_valid;
        err_set[ERR_APPLY_IGN] = cfg_apply;

        // Refill the output register from the skid first so order is kept;
        // a returning read word goes wherever space is left.
        if (out_free) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = rd_pend_q;
            skid_data_d  = rd_data;
          end else if (rd_pend_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = rd_data;
          end else begin
            out_valid_d  = 1'b0;
          end
        end else if (rd_pend_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = rd_data;
        end

        rd_pend_d = 1'b0;
        if ((occ < 2'd2) && (rd_idx_q != RD_END)) begin
          rd_en     = 1'b1;
          rd_idx_d  = rd_idx_q + 1'b1;
          rd_pend_d = 1'b1;
        end

        if (handshake) begin
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == TAP_LAST) begin
            state_d     = S_RUN;
            done_d      = 1'b1;
            out_valid_d = 1'b0;
          end
        end

        // Stall watchdog: abort and leave the FIR disabled rather than
        // running it with a partial tap set.
        if (stalled) begin
          if (to_q == TO_LAST) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_d      = S_UNPROG;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            rd_pend_d    = 1'b0;
            to_d         = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end else begin
          to_d = '0;
        end
      end

      default: begin
        state_d = S_UNPROG;
      end
    endcase

    // A flag raised in the same cycle as a clear survives the clear.
    err_d = (cfg_err_clear ? '0 : err_q) | err_set;
  end

  // State register; reset puts every output back to zero immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_UNPROG;
      flush_q      <= '0;
      rd_idx_q     <= '0;
      rd_pend_q    <= 1'b0;
      tx_idx_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      to_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      rd_idx_q     <= rd_idx_d;
      rd_pend_q    <= rd_pend_d;
      tx_idx_q     <= tx_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      to_q         <= to_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cfg_busy          = (state_q == S_FLUSH) || (state_q == S_STREAM);
  assign cfg_programmed    = (state_q == S_RUN);
  assign fir_enable        = (state_q == S_STREAM) || (state_q == S_RUN);
  assign fir_data_gate     = (state_q == S_RUN);
  assign cfg_done          = done_q;
  assign cfg_err           = err_q;
  assign fir_tap_din       = out_data_q;
  assign fir_tap_din_valid = out_valid_q;

endmodule

// File: tb/tb_config_fir_tap_sequencer.sv
// Self-checking bench for config_fir_tap_sequencer (T=16, G_TIMEOUT=8).
// A per-cycle reference model tracks the programming phase, shadow contents,
// stall count and sticky errors, and every tap handshake is checked against
// the modelled shadow memory. Directed scenarios add literal expectations.
module tb_config_fir_tap_sequencer;
  import config_fir_pkg::*;

  localparam int TB_T   = 16;
  localparam int TB_F   = 2;
  localparam int TB_TO  = 8;

  localparam int PH_IDLE   = 0;
  localparam int PH_FLUSH  = 1;
  localparam int PH_STREAM = 2;
  localparam int PH_RUN    = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [15:0] cfg_wr_data = '0;
  logic        cfg_wr_valid = 1'b0;
  logic        cfg_apply = 1'b0;
  logic        cfg_err_clear = 1'b0;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_programmed;
  logic [2:0]  cfg_err;
  logic        fir_enable;
  logic [15:0] fir_tap_din;
  logic        fir_tap_din_valid;
  logic        fir_tap_din_ready = 1'b0;
  logic        fir_data_gate;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int          m_phase = PH_IDLE;
  int          m_flush = 0;
  int          m_sent  = 0;
  int          m_stall = 0;
  logic [2:0]  m_err   = '0;
  logic        m_done  = 1'b0;
  logic [15:0] m_mem [TB_T];
  logic        p_valid = 1'b0;
  logic [15:0] p_din   = '0;
  int          cyc = 0;

  logic [15:0] seen [$];
  int          hs_first = 0;
  int          hs_last  = 0;
  int          done_cnt = 0;

  logic [15:0] pat = 16'b1001_1010_0110_0101;
  int          pat_i = 0;

  config_fir_tap_sequencer #(
    .G_NUM_STAGES_LOG2  (2),
    .G_STAGE_DEPTH_LOG2 (2),
    .G_TAP_WIDTH        (16),
    .G_FLUSH_CYCLES     (TB_F),
    .G_TIMEOUT          (TB_TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cfg_wr_addr       (cfg_wr_addr),
    .cfg_wr_data       (cfg_wr_data),
    .cfg_wr_valid      (cfg_wr_valid),
    .cfg_apply         (cfg_apply),
    .cfg_err_clear     (cfg_err_clear),
    .cfg_busy          (cfg_busy),
    .cfg_done          (cfg_done),
    .cfg_programmed    (cfg_programmed),
    .cfg_err           (cfg_err),
    .fir_enable        (fir_enable),
    .fir_tap_din       (fir_tap_din),
    .fir_tap_din_valid (fir_tap_din_valid),
    .fir_tap_din_ready (fir_tap_din_ready),
    .fir_data_gate     (fir_data_gate)
  );

  always #5 clk = ~clk;

  // Common comparison: counts every check and reports failures on one line.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  // Drives one cycle of configuration-port activity, then returns strobes low.
  task automatic applyStimulus(input logic wv, input logic [3:0] wa, input logic [15:0] wd,
                               input logic ap, input logic clr);
    cfg_wr_valid  = wv;
    cfg_wr_addr   = wa;
    cfg_wr_data   = wd;
    cfg_apply     = ap;
    cfg_err_clear = clr;
    cycle();
    cfg_wr_valid  = 1'b0;
    cfg_apply     = 1'b0;
    cfg_err_clear = 1'b0;
  endtask

  // Runs until the sequencer stops being busy; mode 0/1 = ready constant,
  // mode 2 = irregular ready pattern.
  task automatic waitIdle(input int mode, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      if (!cfg_busy) break;
      if (mode == 2) begin
        fir_tap_din_ready = pat[pat_i % 16];
        pat_i++;
      end else begin
        fir_tap_din_ready = (mode == 1);
      end
      cycle();
    end
    checkOutput({name, "_finished_in_budget"}, 32'(k < budget), 32'd1);
  endtask

  // Observed tap stream must be 1..16 with tap 3 possibly overridden.
  task automatic checkSeq(input string name, input logic [15:0] tap3);
    checkOutput({name, "_count"}, 32'(seen.size()), 32'd16);
    for (int i = 0; i < TB_T; i++) begin
      logic [15:0] exp;
      exp = (i == 3) ? tap3 : 16'(i + 1);
      checkOutput($sformatf("%s_tap%0d", name, i), 32'(seen[i]), 32'(exp));
    end
  endtask

  // Reference model and per-cycle compare. Inputs still hold the values the
  // last rising edge saw; p_* hold the DUT outputs from before that edge.
  always @(negedge clk) begin
    logic       hs;
    logic       st;
    logic [2:0] eset;
    cyc++;
    if (!reset_n) begin
      m_phase = PH_IDLE;
      m_err   = '0;
      m_done  = 1'b0;
      m_stall = 0;
      p_valid = 1'b0;
      p_din   = '0;
      checkOutput("reset_outputs",
                  32'({cfg_busy, cfg_done, cfg_programmed, cfg_err, fir_enable,
                       fir_tap_din, fir_tap_din_valid, fir_data_gate}), 32'd0);
    end else begin
      hs   = p_valid && fir_tap_din_ready;
      st   = p_valid && !fir_tap_din_ready;
      eset = '0;
      m_done = 1'b0;
      case (m_phase)
        PH_IDLE, PH_RUN: begin
          if (cfg_wr_valid) m_mem[cfg_wr_addr] = cfg_wr_data;
          if (cfg_apply) begin
            m_phase = PH_FLUSH;
            m_flush = TB_F;
          end
        end
        PH_FLUSH: begin
          eset = {1'b0, cfg_apply, cfg_wr_valid};
          m_flush--;
          if (m_flush == 0) begin
            m_phase = PH_STREAM;
            m_sent  = 0;
            m_stall = 0;
          end
        end
        default: begin
          eset = {1'b0, cfg_apply, cfg_wr_valid};
          if (hs) begin
            checkOutput("tap_data", 32'(p_din), 32'(m_mem[m_sent]));
            seen.push_back(p_din);
            if (m_sent == 0) hs_first = cyc;
            hs_last = cyc;
            m_sent++;
            m_stall = 0;
            if (m_sent == TB_T) begin
              m_phase = PH_RUN;
              m_done  = 1'b1;
            end
          end else if (st) begin
            m_stall++;
            if (m_stall == TB_TO) begin
              eset[2] = 1'b1;
              m_phase = PH_IDLE;
            end
          end else begin
            m_stall = 0;
          end
        end
      endcase
      m_err = (cfg_err_clear ? 3'b000 : m_err) | eset;

      checkOutput("busy", 32'(cfg_busy), 32'(m_phase == PH_FLUSH || m_phase == PH_STREAM));
      checkOutput("enable", 32'(fir_enable), 32'(m_phase == PH_STREAM || m_phase == PH_RUN));
      checkOutput("gate", 32'(fir_data_gate), 32'(m_phase == PH_RUN));
      checkOutput("programmed", 32'(cfg_programmed), 32'(m_phase == PH_RUN));
      checkOutput("err", 32'(cfg_err), 32'(m_err));
      checkOutput("done", 32'(cfg_done), 32'(m_done));
      if (m_phase != PH_STREAM) begin
        checkOutput("valid_outside_stream", 32'(fir_tap_din_valid), 32'd0);
      end else if (hs) begin
        checkOutput("back_to_back_valid", 32'(fir_tap_din_valid), 32'd1);
      end else if (st) begin
        checkOutput("stall_valid_hold", 32'(fir_tap_din_valid), 32'd1);
        checkOutput("stall_data_hold", 32'(fir_tap_din), 32'(p_din));
      end
      if (cfg_done) done_cnt++;
      p_valid = fir_tap_din_valid;
      p_din   = fir_tap_din;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) cycle();
    checkOutput("reset_literal",
                32'({cfg_busy, cfg_done, cfg_programmed, cfg_err, fir_enable,
                     fir_tap_din, fir_tap_din_valid, fir_data_gate}), 32'd0);
    reset_n = 1'b1;
    cycle();

    // Load taps 1..16
    for (int i = 0; i < TB_T; i++) begin
      applyStimulus(1'b1, 4'(i), 16'(i + 1), 1'b0, 1'b0);
    end

    // 1) Straight stream with ready held high
    seen.delete();
    done_cnt = 0;
    fir_tap_din_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    n = 0;
    while (!fir_enable && n < 10) begin
      n++;
      cycle();
    end
    checkOutput("flush_low_cycles", 32'(n), 32'd2);
    waitIdle(1, 60, "basic");
    checkSeq("basic", 16'd4);
    checkOutput("basic_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("basic_consecutive", 32'(hs_last - hs_first), 32'd15);
    checkOutput("basic_gate", 32'(fir_data_gate), 32'd1);

    // 2) Irregular ready
    seen.delete();
    done_cnt = 0;
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    waitIdle(2, 120, "toggle");
    checkSeq("toggle", 16'd4);
    checkOutput("toggle_done_pulses", 32'(done_cnt), 32'd1);

    // 3) Timeout with ready stuck low, then recovery
    seen.delete();
    done_cnt = 0;
    fir_tap_din_ready = 1'b0;
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    waitIdle(0, 40, "timeout");
    checkOutput("timeout_err", 32'(cfg_err), 32'b100);
    checkOutput("timeout_enable", 32'(fir_enable), 32'd0);
    checkOutput("timeout_programmed", 32'(cfg_programmed), 32'd0);
    checkOutput("timeout_no_done", 32'(done_cnt), 32'd0);
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("err_cleared", 32'(cfg_err), 32'd0);
    seen.delete();
    fir_tap_din_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    waitIdle(1, 60, "recover");
    checkSeq("recover", 16'd4);

    // 4) Write and apply while busy are refused; update from RUN takes effect
    seen.delete();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd3, 16'h0AAA, 1'b1, 1'b0);
    waitIdle(1, 60, "busy_cfg");
    checkOutput("busy_cfg_err", 32'(cfg_err), 32'b011);
    checkSeq("busy_cfg", 16'd4);
    seen.delete();
    applyStimulus(1'b1, 4'd3, 16'h0BEE, 1'b1, 1'b1);
    waitIdle(1, 60, "update");
    checkOutput("update_err", 32'(cfg_err), 32'd0);
    checkSeq("update", 16'h0BEE);

    // 5) Asynchronous reset after tap 7, then a fresh programming run
    seen.delete();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    n = 0;
    while (seen.size() < 7 && n < 40) begin
      n++;
      cycle();
    end
    checkOutput("midreset_reached_tap7", 32'(seen.size()), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_async_outputs",
                32'({cfg_busy, cfg_done, cfg_programmed, cfg_err, fir_enable,
                     fir_tap_din, fir_tap_din_valid, fir_data_gate}), 32'd0);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    seen.delete();
    applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    waitIdle(1, 60, "after_reset");
    checkSeq("after_reset", 16'h0BEE);
    checkOutput("after_reset_programmed", 32'(cfg_programmed), 32'd1);

    cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
